regbank_v5: RTL and testbench
=============================

# regbank_v5

Parametrised multi-port register bank for the datapath, succeeding the fixed 32x32 bank. Data width and depth are configurable. It has two read ports, two prioritised write ports and optional write-to-read bypass. A per-register pending scoreboard supports operand hazard checks, and a sequenced bulk-clear engine sweeps the bank one entry per cycle.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; NUM_REGS = 2**ADDR_W
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes, and its pending bit is never set
- BYPASS, 1, when 1 same-cycle write data is forwarded to the read ports

- clk  input  1  rising-edge clock, the only clock
- reset  input  1  synchronous, active-high; clears all registers, pending bits and the clear engine
- write  input  1  write enable, port A
- dr  input  ADDR_W  destination address, port A
- wrData  input  DATA_W  write data, port A
- write2  input  1  write enable, port B
- dr2  input  ADDR_W  destination address, port B
- wrData2  input  DATA_W  write data, port B
- sr1, sr2  input  ADDR_W  read addresses
- rdData1, rdData2  output  DATA_W  combinational read data
- reserve  input  1  mark register rsvAddr as pending
- rsvAddr  input  ADDR_W  register to reserve
- pend1, pend2  output  1  pending status of sr1 / sr2
- clear  input  1  one-cycle request to start the bulk clear
- busy  output  1  bulk clear in progress

## Operation
- Storage: NUM_REGS x DATA_W flops, written on the rising edge of clk.
- Writes: each port writes its enabled address on the clock edge.
  - If both ports target the same address, port B wins.
  - Writes to register 0 are dropped when ZERO_REG=1.
- Reads (combinational): rdDataN = regs[srN].
  - With ZERO_REG=1, srN=0 returns 0.
  - With BYPASS=1 and an enabled write to srN in the current cycle, return that write's data; port B takes priority.
  - Bypass never applies to register 0 when ZERO_REG=1.
- Scoreboard: one pending bit per register.
  - Set by reserve on the edge.
  - Cleared by any enabled write (either port) to that address.
  - Reserve and write to the same address in the same cycle leave the bit set (new producer wins).
  - pendN = pending[srN]. With BYPASS=1, pendN is 0 when a same-cycle write to srN exists and no same-cycle reserve targets srN.
- Clear engine FSM, states IDLE and SWEEP, with an ADDR_W-bit index idx:
  - IDLE: clear=1 moves to SWEEP with idx=0.
  - SWEEP: each cycle writes 0 to regs[idx], clears pending[idx], and increments idx.
  - When idx = NUM_REGS-1 has been cleared, return to IDLE; idx wraps to 0.
  - In SWEEP, write, write2, reserve and clear are ignored. Reads still return stored contents, and bypass is disabled.
- Reset dominates every other input, including a sweep in progress.

## Timing
- Reset values: all registers 0, all pending bits 0, FSM in IDLE, idx 0.
  - busy = 0.
  - rdData1/2 = 0 and pend1/2 = 0, since both follow the cleared storage.
- Write-to-read latency:
  - 0 cycles via bypass (BYPASS=1).
  - Otherwise 1 cycle: visible in the cycle after the write edge.
- Reserve-to-pend: visible the cycle after the reserve edge.
- Clear sampled at edge T:
  - busy = 1 from T+1 through T+NUM_REGS.
  - busy = 0 and the whole bank reads 0 from T+NUM_REGS+1.
- Clear requested while busy=1: ignored; it is not queued.
- Reset asserted mid-sweep: at the next edge busy = 0 and all state is zero; the sweep does not resume.
- Inputs must be stable around the rising edge; there are no other handshakes.

## Test plan
- Reset, then write 10*i to registers 0..31 via port A one per cycle, then read sr1=i, sr2=i+1 -> reg 0 reads 0 (ZERO_REG=1), reg i reads 10*i, and sr2=0 after wrap reads 0.
- Same-cycle write dr=dr2=7 with wrData=0x11, wrData2=0x22 -> reg 7 reads 0x22; a write to reg 0 reads back 0.
- BYPASS=1: write 0xABCD to reg 5 while sr1=5 -> rdData1=0xABCD in the same cycle. Repeat with BYPASS=0 -> old value this cycle, 0xABCD the next.
- Reserve reg 9 -> pend1=1 with sr1=9 the next cycle. Port B write to reg 9 clears it. Reserve and write reg 9 in the same cycle -> pend1 stays 1.
- Fill the bank and pulse clear -> busy high for exactly 32 cycles; writes and reserves during the sweep have no effect; all registers read 0 and pend=0 afterwards.
- Pulse clear, assert reset on sweep cycle 10 -> busy=0 at the next edge, all registers read 0, and a subsequent write to reg 3 succeeds.

Source files
------------

// File: rtl/regbank_v5_if.sv
// regbank_v5_if -- bundle of the register bank's datapath-facing signals.
//
// Ports (from the master's point of view):
//   write / dr / wrData      write port A (enable, address, data)
//   write2 / dr2 / wrData2   write port B (enable, address, data), wins over A
//   sr1 / sr2                read addresses
//   rdData1 / rdData2        combinational read data
//   reserve / rsvAddr        mark a register as pending (awaiting a producer)
//   pend1 / pend2            pending status of sr1 / sr2
//   clear                    one-cycle request to start the bulk clear
//   busy                     bulk clear in progress
interface regbank_v5_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              write;
  logic [ADDR_W-1:0] dr;
  logic [DATA_W-1:0] wrData;
  logic              write2;
  logic [ADDR_W-1:0] dr2;
  logic [DATA_W-1:0] wrData2;
  logic [ADDR_W-1:0] sr1;
  logic [ADDR_W-1:0] sr2;
  logic [DATA_W-1:0] rdData1;
  logic [DATA_W-1:0] rdData2;
  logic              reserve;
  logic [ADDR_W-1:0] rsvAddr;
  logic              pend1;
  logic              pend2;
  logic              clear;
  logic              busy;

  modport master (
    output write, dr, wrData, write2, dr2, wrData2, sr1, sr2,
           reserve, rsvAddr, clear,
    input  rdData1, rdData2, pend1, pend2, busy
  );

  modport slave (
    input  write, dr, wrData, write2, dr2, wrData2, sr1, sr2,
           reserve, rsvAddr, clear,
    output rdData1, rdData2, pend1, pend2, busy
  );
endinterface

// File: rtl/regbank_v5.sv
// regbank_v5 -- parametrised 2-read / 2-write register bank with optional
// write-to-read bypass, a per-register pending scoreboard and a sequenced
// bulk-clear engine that zeroes one entry per cycle.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears storage, pending bits and engine
//   bus    regbank_v5_if.slave (see the interface file for the signal list)
//
// Parameters:
//   DATA_W    register width
//   ADDR_W    address width, NUM_REGS = 2**ADDR_W
//   ZERO_REG  register 0 is hard-wired to zero and never pending
//   BYPASS    forward same-cycle write data / pending release to the reads
module regbank_v5 #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic         clk,
  input logic         reset,
  regbank_v5_if.slave bus
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   idx;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;

  logic sweeping;
  logic we_a;
  logic we_b;
  logic rsv_en;

  // The sweep owns the bank: all external updates are masked while it runs,
  // and writes/reserves aimed at a hard-wired zero register are dropped here
  // so neither storage, scoreboard nor bypass ever sees them.
  assign sweeping = (state == SWEEP);
  assign we_a     = bus.write   && !sweeping && !(ZERO_REG && bus.dr == '0);
  assign we_b     = bus.write2  && !sweeping && !(ZERO_REG && bus.dr2 == '0);
  assign rsv_en   = bus.reserve && !sweeping && !(ZERO_REG && bus.rsvAddr == '0);

  // Scoreboard update: writes release, a reserve in the same cycle re-arms
  // the bit because it names the newer producer.
  // NOTE: every always_comb output gets a default on entry, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    pending_nxt = pending;
    if (we_a)   pending_nxt[bus.dr]      = 1'b0;
    if (we_b)   pending_nxt[bus.dr2]     = 1'b0;
    if (rsv_en) pending_nxt[bus.rsvAddr] = 1'b1;
  end

  // NOTE: all state here is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      pending <= '0;
      // NOTE: the storage array is reset explicitly because reset must leave
      // the whole bank reading zero; this keeps it as flops, not a RAM macro.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (sweeping) begin
      regs[idx]    <= '0;
      pending[idx] <= 1'b0;
      idx          <= idx + 1'b1;  // wraps to 0 after the last entry
      if (idx == '1) state <= IDLE;
    end else begin
      // Port B is assigned last so it wins an address collision with port A.
      if (we_a) regs[bus.dr]  <= bus.wrData;
      if (we_b) regs[bus.dr2] <= bus.wrData2;
      pending <= pending_nxt;
      if (bus.clear) begin
        state <= SWEEP;
        idx   <= '0;
      end
    end
  end

  // Read ports, handled as a two-entry array so both share one description.
  logic [ADDR_W-1:0] sr   [2];
  logic [DATA_W-1:0] rd   [2];
  logic              pend [2];

  assign sr[0] = bus.sr1;
  assign sr[1] = bus.sr2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p]   = regs[sr[p]];
      pend[p] = pending[sr[p]];
      if (BYPASS) begin
        // we_a/we_b are already masked during a sweep and for register 0,
        // which disables the bypass in exactly those cases.
        if (we_b && bus.dr2 == sr[p])     rd[p] = bus.wrData2;
        else if (we_a && bus.dr == sr[p]) rd[p] = bus.wrData;
        if (((we_a && bus.dr == sr[p]) || (we_b && bus.dr2 == sr[p])) &&
            !(rsv_en && bus.rsvAddr == sr[p]))
          pend[p] = 1'b0;
      end
      if (ZERO_REG && sr[p] == '0) begin
        rd[p]   = '0;
        pend[p] = 1'b0;
      end
    end
  end

  assign bus.rdData1 = rd[0];
  assign bus.rdData2 = rd[1];
  assign bus.pend1   = pend[0];
  assign bus.pend2   = pend[1];
  assign bus.busy    = sweeping;

endmodule

// File: tb/tb_regbank_v5.sv
// tb_regbank_v5 -- directed, table-driven bench for regbank_v5.
// Two instances share one stimulus: u_byp (BYPASS=1) and u_nob (BYPASS=0),
// so the same vector shows forwarding on one and one-cycle latency on the
// other. All expected values are hand-computed constants.
module tb_regbank_v5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        write, write2, reserve, clear;
  logic [4:0]  dr, dr2, sr1, sr2, rsv_addr;
  logic [31:0] wr_data, wr_data2;

  regbank_v5_if #(.DATA_W(32), .ADDR_W(5)) bus_byp ();
  regbank_v5_if #(.DATA_W(32), .ADDR_W(5)) bus_nob ();

  assign bus_byp.write   = write;    assign bus_nob.write   = write;
  assign bus_byp.dr      = dr;       assign bus_nob.dr      = dr;
  assign bus_byp.wrData  = wr_data;  assign bus_nob.wrData  = wr_data;
  assign bus_byp.write2  = write2;   assign bus_nob.write2  = write2;
  assign bus_byp.dr2     = dr2;      assign bus_nob.dr2     = dr2;
  assign bus_byp.wrData2 = wr_data2; assign bus_nob.wrData2 = wr_data2;
  assign bus_byp.sr1     = sr1;      assign bus_nob.sr1     = sr1;
  assign bus_byp.sr2     = sr2;      assign bus_nob.sr2     = sr2;
  assign bus_byp.reserve = reserve;  assign bus_nob.reserve = reserve;
  assign bus_byp.rsvAddr = rsv_addr; assign bus_nob.rsvAddr = rsv_addr;
  assign bus_byp.clear   = clear;    assign bus_nob.clear   = clear;

  regbank_v5 #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_byp (
    .clk(clk), .reset(reset), .bus(bus_byp.slave)
  );
  regbank_v5 #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_nob (
    .clk(clk), .reset(reset), .bus(bus_nob.slave)
  );

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    write = 1'b0; dr = '0; wr_data = '0;
    write2 = 1'b0; dr2 = '0; wr_data2 = '0;
    reserve = 1'b0; rsv_addr = '0; clear = 1'b0;
  endtask

  typedef struct {
    logic        wr;  logic [4:0] dr;  logic [31:0] wd;
    logic        wr2; logic [4:0] dr2; logic [31:0] wd2;
    logic        rsv; logic [4:0] ra;
    logic [4:0]  s1;  logic [4:0] s2;
    logic [31:0] e1;  logic [31:0] e2;          // bypass instance reads
    logic        ep1; logic        ep2;         // bypass instance pending
    logic [31:0] n1;  logic        np1;         // no-bypass instance, port 1
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  initial begin
    // Applied after the bank holds regs[i] = 10*i.
    //           wr   dr     wd       wr2  dr2    wd2      rsv  ra    s1     s2     e1         e2         ep1  ep2  n1         np1
    vecs[0]  = '{1'b1, 5'd7,  32'h11,  1'b1, 5'd7,  32'h22, 1'b0, 5'd0, 5'd7,  5'd0,  32'h22,    32'd0,     1'b0, 1'b0, 32'd70,    1'b0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,   1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 5'd7,  5'd3,  32'h22,    32'd30,    1'b0, 1'b0, 32'h22,    1'b0};
    vecs[2]  = '{1'b1, 5'd0,  32'h55,  1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 5'd0,  5'd0,  32'd0,     32'd0,     1'b0, 1'b0, 32'd0,     1'b0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,   1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 5'd2,  5'd7,  32'd20,    32'h22,    1'b0, 1'b0, 32'd20,    1'b0};
    vecs[4]  = '{1'b1, 5'd5,  32'hABCD,1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 5'd5,  5'd5,  32'hABCD,  32'hABCD,  1'b0, 1'b0, 32'd50,    1'b0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,   1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 5'd5,  5'd6,  32'hABCD,  32'd60,    1'b0, 1'b0, 32'hABCD,  1'b0};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,   1'b0, 5'd0,  32'h0,  1'b1, 5'd9, 5'd9,  5'd9,  32'd90,    32'd90,    1'b0, 1'b0, 32'd90,    1'b0};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,   1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 5'd9,  5'd8,  32'd90,    32'd80,    1'b1, 1'b0, 32'd90,    1'b1};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,   1'b1, 5'd9,  32'h99, 1'b0, 5'd0, 5'd9,  5'd10, 32'h99,    32'd100,   1'b0, 1'b0, 32'd90,    1'b1};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,   1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 5'd9,  5'd11, 32'h99,    32'd110,   1'b0, 1'b0, 32'h99,    1'b0};
    vecs[10] = '{1'b1, 5'd9,  32'h123, 1'b0, 5'd0,  32'h0,  1'b1, 5'd9, 5'd9,  5'd9,  32'h123,   32'h123,   1'b0, 1'b0, 32'h99,    1'b0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,   1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 5'd9,  5'd0,  32'h123,   32'd0,     1'b1, 1'b0, 32'h123,   1'b1};
    vecs[12] = '{1'b0, 5'd0,  32'h0,   1'b0, 5'd0,  32'h0,  1'b1, 5'd0, 5'd0,  5'd9,  32'd0,     32'h123,   1'b0, 1'b1, 32'd0,     1'b0};
    vecs[13] = '{1'b0, 5'd0,  32'h0,   1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 5'd0,  5'd9,  32'd0,     32'h123,   1'b0, 1'b1, 32'd0,     1'b0};
    vecs[14] = '{1'b1, 5'd12, 32'h1,   1'b1, 5'd13, 32'h2,  1'b0, 5'd0, 5'd12, 5'd13, 32'h1,     32'h2,     1'b0, 1'b0, 32'd120,   1'b0};

    idle_inputs();
    sr1 = 5'd3; sr2 = 5'd31;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Reset state.
    check("reset busy", 32'(bus_byp.busy), 32'd0);
    check("reset rd1", bus_byp.rdData1, 32'd0);
    check("reset rd2", bus_byp.rdData2, 32'd0);
    check("reset pend1", 32'(bus_byp.pend1), 32'd0);
    check("reset pend2", 32'(bus_byp.pend2), 32'd0);
    check("reset nob busy", 32'(bus_nob.busy), 32'd0);

    // Fill: reg i <- 10*i through port A.
    for (int i = 0; i < 32; i++) begin
      write = 1'b1; dr = 5'(i); wr_data = 32'(10 * i);
      step();
    end
    idle_inputs();

    for (int i = 0; i < 32; i++) begin
      int j;
      j = (i + 1) % 32;
      sr1 = 5'(i); sr2 = 5'(j);
      #1;
      check($sformatf("fill rd1[%0d]", i), bus_byp.rdData1, (i == 0) ? 32'd0 : 32'(10 * i));
      check($sformatf("fill rd2[%0d]", j), bus_byp.rdData2, (j == 0) ? 32'd0 : 32'(10 * j));
      step();
    end

    // Directed vectors: outputs compared before the edge that applies them.
    for (int i = 0; i < NV; i++) begin
      write = vecs[i].wr;   dr = vecs[i].dr;   wr_data = vecs[i].wd;
      write2 = vecs[i].wr2; dr2 = vecs[i].dr2; wr_data2 = vecs[i].wd2;
      reserve = vecs[i].rsv; rsv_addr = vecs[i].ra;
      sr1 = vecs[i].s1; sr2 = vecs[i].s2;
      #1;
      check($sformatf("vec%0d rd1", i), bus_byp.rdData1, vecs[i].e1);
      check($sformatf("vec%0d rd2", i), bus_byp.rdData2, vecs[i].e2);
      check($sformatf("vec%0d pend1", i), 32'(bus_byp.pend1), 32'(vecs[i].ep1));
      check($sformatf("vec%0d pend2", i), 32'(bus_byp.pend2), 32'(vecs[i].ep2));
      check($sformatf("vec%0d nob rd1", i), bus_nob.rdData1, vecs[i].n1);
      check($sformatf("vec%0d nob pend1", i), 32'(bus_nob.pend1), 32'(vecs[i].np1));
      step();
    end
    idle_inputs();

    // Bulk clear. Bank now holds 10*i except reg5=0xABCD, reg7=0x22,
    // reg9=0x123 (pending), reg12=1, reg13=2. Clear sampled at edge T.
    clear = 1'b1;
    step();
    // Junk traffic during the whole sweep must be ignored, including a
    // same-cycle write to the read address (no bypass while sweeping).
    write = 1'b1; dr = 5'd20; wr_data = 32'hDEAD;
    write2 = 1'b1; dr2 = 5'd21; wr_data2 = 32'hBEEF;
    reserve = 1'b1; rsv_addr = 5'd25;
    sr1 = 5'd20; sr2 = 5'd9;
    for (int k = 0; k < 32; k++) begin
      #1;
      // After edge T+k, entries 0..k-1 have been zeroed.
      check($sformatf("sweep%0d busy", k), 32'(bus_byp.busy), 32'd1);
      check($sformatf("sweep%0d rd1", k), bus_byp.rdData1, (k <= 20) ? 32'd200 : 32'd0);
      check($sformatf("sweep%0d pend2", k), 32'(bus_byp.pend2), (k <= 9) ? 32'd1 : 32'd0);
      step();
    end
    idle_inputs();
    #1;
    check("sweep end busy", 32'(bus_byp.busy), 32'd0);
    for (int i = 0; i < 32; i++) begin
      sr1 = 5'(i); sr2 = 5'(31 - i);
      #1;
      check($sformatf("cleared rd1[%0d]", i), bus_byp.rdData1, 32'd0);
      check($sformatf("cleared pend1[%0d]", i), 32'(bus_byp.pend1), 32'd0);
      check($sformatf("cleared nob rd2[%0d]", 31 - i), bus_nob.rdData2, 32'd0);
      step();
    end
    check("no requeued sweep", 32'(bus_byp.busy), 32'd0);

    // Reset in the middle of a sweep.
    write = 1'b1; dr = 5'd30; wr_data = 32'h3030;
    step();
    idle_inputs();
    reserve = 1'b1; rsv_addr = 5'd28;
    step();
    idle_inputs();
    clear = 1'b1;
    step();                        // edge T
    clear = 1'b0;
    for (int k = 0; k < 10; k++) step();   // through edge T+10
    sr1 = 5'd30; sr2 = 5'd28;
    #1;
    check("mid sweep busy", 32'(bus_byp.busy), 32'd1);
    check("mid sweep reg30", bus_byp.rdData1, 32'h3030);
    check("mid sweep pend28", 32'(bus_byp.pend2), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset mid busy", 32'(bus_byp.busy), 32'd0);
    check("reset mid reg30", bus_byp.rdData1, 32'd0);
    check("reset mid pend28", 32'(bus_byp.pend2), 32'd0);
    step();
    check("sweep not resumed", 32'(bus_byp.busy), 32'd0);
    write = 1'b1; dr = 5'd3; wr_data = 32'h3333;
    step();
    idle_inputs();
    sr1 = 5'd3; sr2 = 5'd30;
    #1;
    check("post reset reg3", bus_byp.rdData1, 32'h3333);
    check("post reset nob reg3", bus_nob.rdData1, 32'h3333);
    check("post reset reg30", bus_byp.rdData2, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
